// File: rtl/fns_tsv_allocator.sv
// fns_tsv_allocator: sequential Fibonacci-weight allocator for a TSV bundle.
// Scans N = X+Y fault flags one TSV per clock. Healthy TSVs get consecutive
// Fibonacci weights (1,2,3,5,...) until X are enabled. Later healthy TSVs stay
// redundant. Faulty TSVs are skipped and consume no weight.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - scan request, sampled only in idle
//   f_flag    - per-TSV fault flags (1 = faulty), latched when start is accepted
//   busy      - high from start acceptance through the done cycle
//   out_valid - one cycle per scanned TSV
//   out_idx   - index of the TSV reported this cycle
//   out_en    - enable of the reported TSV
//   out_wgt   - weight of the reported TSV (0 when not enabled)
//   en_flag   - accumulated enable map
//   wgt_sum   - sum of the assigned weights
//   fail      - fewer than X healthy TSVs were found
//   done      - one-cycle pulse when results are final
module fns_tsv_allocator #(
    parameter int unsigned X     = 4,
    parameter int unsigned Y     = 2,
    parameter int unsigned WGT_W = 8,
    parameter int unsigned N     = X + Y,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N-1:0]       f_flag,
    output logic               busy,
    output logic               out_valid,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_en,
    output logic [WGT_W-1:0]   out_wgt,
    output logic [N-1:0]       en_flag,
    output logic [WGT_W+1:0]   wgt_sum,
    output logic               fail,
    output logic               done
);

    localparam int unsigned CNT_W = $clog2(X + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(X);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

    state_t             state_q;
    logic [N-1:0]       flags_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WGT_W-1:0]   fib_prev_q;
    logic [WGT_W-1:0]   fib_cur_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            flags_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            fib_prev_q <= '0;
            fib_cur_q  <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_en     <= 1'b0;
            out_wgt    <= '0;
            en_flag    <= '0;
            wgt_sum    <= '0;
            fail       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        flags_q    <= f_flag;
                        en_flag    <= '0;
                        wgt_sum    <= '0;
                        fail       <= 1'b0;
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        fib_prev_q <= WGT_W'(1);
                        fib_cur_q  <= WGT_W'(1);
                        busy       <= 1'b1;
                        state_q    <= StScan;
                    end
                end
                StScan: begin
                    out_valid <= 1'b1;
                    out_idx   <= idx_q;
                    if (!flags_q[idx_q] && (cnt_q < CNT_MAX)) begin
                        out_en         <= 1'b1;
                        out_wgt        <= fib_cur_q;
                        en_flag[idx_q] <= 1'b1;
                        wgt_sum        <= wgt_sum + (WGT_W + 2)'(fib_cur_q);
                        cnt_q          <= cnt_q + CNT_W'(1);
                        // The step after the X-th enable may wrap; it is never used.
                        fib_prev_q     <= fib_cur_q;
                        fib_cur_q      <= fib_prev_q + fib_cur_q;
                    end else begin
                        out_en  <= 1'b0;
                        out_wgt <= '0;
                    end
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // Two cycles here: the first raises done, the second drops it.
                    if (!done) begin
                        out_valid <= 1'b0;
                        out_en    <= 1'b0;
                        out_wgt   <= '0;
                        done      <= 1'b1;
                        fail      <= (cnt_q < CNT_MAX);
                    end else begin
                        done    <= 1'b0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fns_tsv_allocator.sv
module tb_fns_tsv_allocator;

    localparam int X     = 4;
    localparam int Y     = 2;
    localparam int N     = X + Y;
    localparam int WGT_W = 8;
    localparam int IDX_W = 3;

    typedef logic [N-1:0][WGT_W-1:0] wvec_t;

    typedef struct {
        logic [N-1:0]     flags;
        wvec_t            w;
        logic [N-1:0]     en;
        logic [WGT_W+1:0] sum;
        logic             fl;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [N-1:0]       f_flag;
    logic               busy;
    logic               out_valid;
    logic [IDX_W-1:0]   out_idx;
    logic               out_en;
    logic [WGT_W-1:0]   out_wgt;
    logic [N-1:0]       en_flag;
    logic [WGT_W+1:0]   wgt_sum;
    logic               fail;
    logic               done;

    int errors = 0;
    int checks = 0;

    fns_tsv_allocator #(
        .X     (X),
        .Y     (Y),
        .WGT_W (WGT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .f_flag    (f_flag),
        .busy      (busy),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_en    (out_en),
        .out_wgt   (out_wgt),
        .en_flag   (en_flag),
        .wgt_sum   (wgt_sum),
        .fail      (fail),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // F(1) = F(2) = 1
    function automatic int fib(input int k);
        int a;
        int b;
        int t;
        a = 1;
        b = 1;
        for (int i = 2; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    // The j-th healthy TSV (j from 0) among the first X gets weight F(j+2).
    task automatic model(input logic [N-1:0] fl, output wvec_t w, output logic [N-1:0] en,
                         output logic [WGT_W+1:0] sum, output logic ffail);
        int used;
        int total;
        used  = 0;
        total = 0;
        w     = '0;
        en    = '0;
        for (int i = 0; i < N; i++) begin
            if (!fl[i] && used < X) begin
                w[i]  = WGT_W'(fib(used + 2));
                en[i] = 1'b1;
                total = total + fib(used + 2);
                used++;
            end
        end
        sum   = (WGT_W + 2)'(total);
        ffail = (used < X);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_idx"},   32'(out_idx),   32'd0);
        check({tag, "_out_en"},    32'(out_en),    32'd0);
        check({tag, "_out_wgt"},   32'(out_wgt),   32'd0);
        check({tag, "_en_flag"},   32'(en_flag),   32'd0);
        check({tag, "_wgt_sum"},   32'(wgt_sum),   32'd0);
        check({tag, "_fail"},      32'(fail),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
    endtask

    // Wait (bounded) for the done pulse, then check final results.
    task automatic wait_done_and_check(input string tag, input logic [N-1:0] exp_en,
                                       input logic [WGT_W+1:0] exp_sum, input logic exp_fail);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_en_flag"}, 32'(en_flag), 32'(exp_en));
        check({tag, "_wgt_sum"}, 32'(wgt_sum), 32'(exp_sum));
        check({tag, "_fail"},    32'(fail),    32'(exp_fail));
        @(negedge clk);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    // Full cycle-accurate scan check. With hold set, start stays high throughout
    // and f_flag is inverted mid-scan; the follow-on scan must start only after idle.
    task automatic run_scan(input string tag, input logic [N-1:0] flags, input wvec_t exp_w,
                            input logic [N-1:0] exp_en, input logic [WGT_W+1:0] exp_sum,
                            input logic exp_fail, input bit hold);
        wvec_t            w2;
        logic [N-1:0]     en2;
        logic [WGT_W+1:0] sum2;
        logic             fl2;
        @(negedge clk);
        f_flag = flags;
        start  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        @(negedge clk);
        check({tag, "_busy_on"},   32'(busy),      32'd1);
        check({tag, "_no_valid0"}, 32'(out_valid), 32'd0);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (hold && k == 2) f_flag = ~flags;
            check($sformatf("%s_valid%0d", tag, k), 32'(out_valid), 32'd1);
            check($sformatf("%s_idx%0d", tag, k),   32'(out_idx),   32'(k));
            check($sformatf("%s_en%0d", tag, k),    32'(out_en),    32'(exp_en[k]));
            check($sformatf("%s_wgt%0d", tag, k),   32'(out_wgt),   32'(exp_w[k]));
            check($sformatf("%s_nodone%0d", tag, k), 32'(done),     32'd0);
        end
        @(negedge clk);
        check({tag, "_done"},      32'(done),      32'd1);
        check({tag, "_valid_off"}, 32'(out_valid), 32'd0);
        check({tag, "_busy_done"}, 32'(busy),      32'd1);
        check({tag, "_en_flag"},   32'(en_flag),   32'(exp_en));
        check({tag, "_wgt_sum"},   32'(wgt_sum),   32'(exp_sum));
        check({tag, "_fail"},      32'(fail),      32'(exp_fail));
        @(negedge clk);
        check({tag, "_done_off"},  32'(done),      32'd0);
        check({tag, "_busy_off"},  32'(busy),      32'd0);
        check({tag, "_en_hold"},   32'(en_flag),   32'(exp_en));
        check({tag, "_sum_hold"},  32'(wgt_sum),   32'(exp_sum));
        if (hold) begin
            model(f_flag, w2, en2, sum2, fl2);
            @(negedge clk);
            check({tag, "_restart"}, 32'(busy), 32'd1);
            start = 1'b0;
            wait_done_and_check({tag, "_second"}, en2, sum2, fl2);
        end
    endtask

    vec_t             tbl[4];
    wvec_t            mw;
    logic [N-1:0]     men;
    logic [WGT_W+1:0] msum;
    logic             mfail;
    logic [N-1:0]     rflags;

    initial begin
        tbl[0] = '{flags: 6'b000000, w: {8'd0, 8'd0, 8'd5, 8'd3, 8'd2, 8'd1},
                   en: 6'b001111, sum: 10'd11, fl: 1'b0};
        tbl[1] = '{flags: 6'b000101, w: {8'd5, 8'd3, 8'd2, 8'd0, 8'd1, 8'd0},
                   en: 6'b111010, sum: 10'd11, fl: 1'b0};
        tbl[2] = '{flags: 6'b010011, w: {8'd3, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0},
                   en: 6'b101100, sum: 10'd6, fl: 1'b1};
        tbl[3] = '{flags: 6'b111111, w: '0, en: 6'b000000, sum: 10'd0, fl: 1'b1};

        rst_n  = 1'b0;
        start  = 1'b0;
        f_flag = '0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_scan($sformatf("tbl%0d", i), tbl[i].flags, tbl[i].w, tbl[i].en,
                     tbl[i].sum, tbl[i].fl, 1'b0);
        end

        // Start held high, f_flag toggled mid-scan.
        run_scan("hold", tbl[1].flags, tbl[1].w, tbl[1].en, tbl[1].sum, tbl[1].fl, 1'b1);

        // Asynchronous reset on the third out_valid cycle.
        @(negedge clk);
        f_flag = '0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_valid", 32'(out_valid), 32'd1);
        check("rst_mid_idx",   32'(out_idx),   32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_stays_idle", 32'(busy), 32'd0);
        run_scan("after_rst", tbl[0].flags, tbl[0].w, tbl[0].en, tbl[0].sum, tbl[0].fl, 1'b0);

        // Randomised scans against the reference model.
        for (int r = 0; r < 24; r++) begin
            rflags = N'($urandom);
            model(rflags, mw, men, msum, mfail);
            run_scan($sformatf("rnd%0d", r), rflags, mw, men, msum, mfail, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
